unpacker: RTL and testbench
===========================

UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 SHALL have parameter IN, default 8: chunks per accepted input word.
REQ-002 SHALL have parameter OUT, default 3: chunks per emitted output beat.
REQ-003 SHALL have parameter W, default 8: bits per chunk.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_val, input, 1: input word valid.
REQ-007 SHALL have port i_rdy, output, 1: input word accepted when i_val && i_rdy (push).
REQ-008 SHALL have port i_data, input, W*IN: chunk k at bits [W*k+W-1:W*k], chunk 0 first.
REQ-009 SHALL have port i_cnt, input, clog2(IN+1): valid chunks in word, taken from chunk 0 upward.
REQ-010 SHALL have port i_last, input, 1: word ends a packet.
REQ-011 SHALL have port o_val, output, 1: output beat valid.
REQ-012 SHALL have port o_rdy, input, 1: beat consumed when o_val && o_rdy (pop).
REQ-013 SHALL have port o_data, output, W*OUT: chunk 0 in the low bits; unused chunks zero.
REQ-014 SHALL have port o_cnt, output, clog2(OUT+1): valid chunks in the beat.
REQ-015 SHALL have port o_last, output, 1: beat ends a packet.

Function
REQ-016 SHALL buffer up to BUFF = IN+OUT-1 chunks in arrival order, holding occupancy v and a pending-last flag lp.
REQ-017 SHALL treat i_cnt = 0 or i_cnt > IN as IN; i_cnt < IN with i_last = 0 is a protocol error and SHALL be handled as IN.
REQ-018 SHALL drive o_val = (v >= OUT) || (lp && v > 0), as a registered-state function with no input-to-o_val combinational path.
REQ-019 SHALL drive o_cnt = min(v, OUT) and o_data = the oldest o_cnt chunks.
REQ-020 SHALL drive o_last = lp && v <= OUT.
REQ-021 SHALL drive i_rdy = !lp && (v - (pop ? o_cnt : 0) + IN <= BUFF); i_rdy may depend combinationally on o_rdy.
REQ-022 SHALL, on pop, shift the buffer down by o_cnt chunks, and on push, append i_cnt chunks after the post-pop remainder, both in the same cycle.
REQ-023 SHALL set lp on a push with i_last = 1 and clear lp on a pop with o_last = 1.
REQ-024 SHALL hold i_rdy low while lp is set, so a new packet is accepted one cycle after the last beat pops at the earliest.
REQ-025 SHALL keep o_data, o_cnt and o_last stable while o_val && !o_rdy.
REQ-026 SHALL drop no chunk and duplicate no chunk; output order equals input order.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force v = 0, lp = 0 and all buffered chunks to 0, giving o_val = 0, o_data = 0, o_cnt = 0, o_last = 0 and i_rdy = 1.
REQ-028 SHALL, on reset assertion mid-packet, discard the partial packet; the first word after release starts a new packet.

Configuration
REQ-029 SHALL, with macro UNPACKER_PKT_COUNT_EN defined, add output o_pkts (16 bits), reset to 0, which increments on each pop with o_last = 1 and saturates at 0xFFFF.
REQ-030 SHALL, without UNPACKER_PKT_COUNT_EN, have no o_pkts port and no counter logic.

Structure
REQ-031 SHALL place the clog2 function and the BUFF derivation in shared package unpacker_pkg.
REQ-032 SHALL be implemented as a single module; a sub-module is not warranted.

Verification
REQ-033 Reset: rst_n = 0 mid-traffic -> o_val = 0 and i_rdy = 1 in the same cycle, before any clock edge.
REQ-034 Streaming: IN=8, OUT=3, W=8, o_rdy = 1; 3 words of i_cnt = 8, i_last = 0, chunks 0x00..0x17 -> 8 beats in order, each o_cnt = 3, o_last = 0.
REQ-035 Short packet: one word, i_cnt = 5, i_last = 1, chunks 0x01..0x05 -> beat {01,02,03} o_cnt = 3 o_last = 0, then beat {04,05,00} o_cnt = 2 o_last = 1; i_rdy = 0 until the cycle after the last pop.
REQ-036 Backpressure: o_rdy = 0; push 8 chunks -> i_rdy = 0; then o_rdy pulsed once per cycle -> i_rdy returns to 1 only once v <= 2 (or at v = 5 in a pop cycle); data unchanged while stalled.
REQ-037 Abort: assert rst_n = 0 after 2 beats of a 16-chunk packet -> outputs clear; next packet of 3 chunks with i_last = 1 -> one beat, o_cnt = 3, o_last = 1.
REQ-038 Count: with UNPACKER_PKT_COUNT_EN, 3 packets of sizes 1, 8 and 13 -> o_pkts = 3.

Source files
------------

// File: rtl/unpacker_pkg.sv
// unpacker_pkg: shared width helper and buffer-depth derivation for the unpacker
package unpacker_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int buff_size(input int in_chunks, input int out_chunks);
    return in_chunks + out_chunks - 1;
  endfunction
endpackage

// File: rtl/unpacker.sv
// unpacker: re-chunks IN-chunk input words into OUT-chunk output beats; UNPACKER_PKT_COUNT_EN adds o_pkts
module unpacker
  import unpacker_pkg::*;
#(
  parameter int IN  = 8,
  parameter int OUT = 3,
  parameter int W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_val,
  output logic                       i_rdy,
  input  logic [W*IN-1:0]            i_data,
  input  logic [clog2(IN+1)-1:0]     i_cnt,
  input  logic                       i_last,
  output logic                       o_val,
  input  logic                       o_rdy,
  output logic [W*OUT-1:0]           o_data,
  output logic [clog2(OUT+1)-1:0]    o_cnt,
  output logic                       o_last
`ifdef UNPACKER_PKT_COUNT_EN
  ,
  output logic [15:0]                o_pkts
`endif
);
  localparam int BUFF = buff_size(IN, OUT);
  localparam int CW   = clog2(BUFF + IN + 1);
  localparam int OCW  = clog2(OUT + 1);
  logic [W*BUFF-1:0] chunks_q, chunks_d, in_ext;
  logic [W*IN-1:0]   in_mask;
  logic [CW-1:0]     v_q, v_d, pc, rem, icnt;
  logic              lp_q, lp_d, pop, push;
  // outputs come only from state; chunks above v are kept zero so o_data needs no mask
  always_comb begin
    o_val    = (v_q >= CW'(OUT)) || (lp_q && v_q != '0);
    o_cnt    = (v_q >= CW'(OUT)) ? OCW'(OUT) : OCW'(v_q);
    o_data   = chunks_q[W*OUT-1:0];
    o_last   = lp_q && (v_q <= CW'(OUT));
    pop      = o_val && o_rdy;
    pc       = pop ? CW'(o_cnt) : '0;
    rem      = v_q - pc;
    i_rdy    = !lp_q && (rem + CW'(IN) <= CW'(BUFF));
    push     = i_val && i_rdy;
    icnt     = (i_cnt == '0 || CW'(i_cnt) > CW'(IN) || !i_last) ? CW'(IN) : CW'(i_cnt);
    in_mask  = ~({(W*IN){1'b1}} << (icnt * W));
    in_ext   = '0;
    in_ext[W*IN-1:0] = i_data & in_mask;
    chunks_d = (chunks_q >> (pc * W)) | (push ? (in_ext << (rem * W)) : '0);
    v_d      = rem + (push ? icnt : '0);
    lp_d     = (push && i_last) || (lp_q && !(pop && o_last));
  end
  // buffer, occupancy and pending-last registers; reset discards any partial packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunks_q <= '0;
      v_q      <= '0;
      lp_q     <= 1'b0;
    end else begin
      chunks_q <= chunks_d;
      v_q      <= v_d;
      lp_q     <= lp_d;
    end
  end
`ifdef UNPACKER_PKT_COUNT_EN
  logic [15:0] pkts_q, pkts_d;
  // count packet-ending pops, saturating at all ones
  always_comb pkts_d = (pop && o_last && pkts_q != 16'hFFFF) ? pkts_q + 16'd1 : pkts_q;
  // packet counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkts_q <= '0;
    else pkts_q <= pkts_d;
  end
  assign o_pkts = pkts_q;
`endif
endmodule

// File: tb/tb_unpacker.sv
// tb_unpacker: randomized and directed stimulus checked against a chunk-queue reference model
module tb_unpacker;
  localparam int IN = 8, OUT = 3, W = 8, BUFF = IN + OUT - 1;
  logic clk = 1'b0, rst_n = 1'b0, i_val = 1'b0, i_last = 1'b0, o_rdy = 1'b0;
  logic [W*IN-1:0] i_data = '0;
  logic [3:0] i_cnt = '0;
  logic i_rdy, o_val, o_last;
  logic [W*OUT-1:0] o_data;
  logic [1:0] o_cnt;
`ifdef UNPACKER_PKT_COUNT_EN
  logic [15:0] o_pkts;
`endif
  int n_chk = 0, n_ok = 0, pkts = 0;
  logic [7:0] q[$];
  bit lp = 0, acc = 0;

  unpacker #(.IN(IN), .OUT(OUT), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_val(i_val), .i_rdy(i_rdy), .i_data(i_data),
    .i_cnt(i_cnt), .i_last(i_last), .o_val(o_val), .o_rdy(o_rdy),
    .o_data(o_data), .o_cnt(o_cnt), .o_last(o_last)
`ifdef UNPACKER_PKT_COUNT_EN
    , .o_pkts(o_pkts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic rst_checks();
    check("rst_o_val", 64'(o_val), 64'(0));
    check("rst_i_rdy", 64'(i_rdy), 64'(1));
    check("rst_o_cnt", 64'(o_cnt), 64'(0));
    check("rst_o_data", 64'(o_data), 64'(0));
    check("rst_o_last", 64'(o_last), 64'(0));
  endtask

  task automatic cyc(input logic iv, input logic [63:0] d, input logic [3:0] c, input logic l, input logic r);
    int v, oc, pc, eff;
    logic ov, ol, ir;
    logic [23:0] od;
    @(negedge clk);
    i_val = iv; i_data = d; i_cnt = c; i_last = l; o_rdy = r;
    #1;
    v  = q.size();
    oc = (v < OUT) ? v : OUT;
    ov = (v >= OUT) || (lp && v > 0);
    ol = lp && (v <= OUT);
    od = '0;
    for (int k = 0; k < oc; k++) od[8*k +: 8] = q[k];
    pc = (ov && r) ? oc : 0;
    ir = !lp && (v - pc + IN <= BUFF);
    check("o_val", 64'(o_val), 64'(ov));
    check("o_cnt", 64'(o_cnt), 64'(oc));
    check("o_data", 64'(o_data), 64'(od));
    check("o_last", 64'(o_last), 64'(ol));
    check("i_rdy", 64'(i_rdy), 64'(ir));
`ifdef UNPACKER_PKT_COUNT_EN
    check("o_pkts", 64'(o_pkts), 64'(pkts));
`endif
    @(posedge clk);
    if (ov && r) begin
      repeat (oc) void'(q.pop_front());
      if (ol) begin
        lp = 0;
        if (pkts < 65535) pkts++;
      end
    end
    acc = iv && ir;
    if (acc) begin
      eff = (c == 0 || c > IN || !l) ? IN : int'(c);
      for (int k = 0; k < eff; k++) q.push_back(d[8*k +: 8]);
      if (l) lp = 1;
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] c, input logic l, input logic r);
    int n;
    n = 0;
    do begin
      cyc(1'b1, d, c, l, r);
      n++;
    end while (!acc && n < 40);
    check("send_accepted", 64'(acc), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_val = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_checks();
    q.delete();
    lp = 0;
    pkts = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] word(input int base);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(base + k);
    return d;
  endfunction

  initial begin
    #3 rst_checks();
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 3; w++) send(word(8 * w), 4'd8, 1'b0, 1'b1);
    repeat (10) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    send(64'h0504030201, 4'd5, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    send(word(8'h30), 4'd8, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    send(word(8'h40), 4'd8, 1'b1, 1'b1);
    repeat (8) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    send(word(8'h50), 4'd8, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    do_reset();
    send(64'h636261, 4'd3, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    send(64'h71, 4'd1, 1'b1, 1'b1);
    send(word(8'h80), 4'd8, 1'b1, 1'b1);
    send(word(8'h90), 4'd8, 1'b0, 1'b1);
    send(word(8'hA0), 4'd5, 1'b1, 1'b1);
    repeat (8) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
    end
    repeat (20) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
